// File: rtl/rd_seq_param.sv
// rd_seq_param: parametrised sequential restoring divider, one quotient bit per clock
module rd_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] xr, yr, a, p, m;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sh;
  logic [WIDTH+1:0] diff;
  logic sm, sq, sr, zf, sx, sy;
  assign sx = sm & xr[WIDTH-1];
  assign sy = sm & yr[WIDTH-1];
  // {P,A} shifted left by one and the trial subtraction; diff MSB set means restore
  assign sh = {p, a[WIDTH-1]};
  assign diff = {1'b0, sh} - {2'b0, m};
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state; a zero divisor skips the iterations but still goes through FIX to load results
  always_comb
    state_n = (state == IDLE) ? (start ? PREP : IDLE) :
              (state == PREP) ? ((yr == '0) ? FIX : ITER) :
              (state == ITER) ? ((cnt == '0) ? FIX : ITER) :
              (state == FIX)  ? DONE : IDLE;
  // status outputs decoded from state
  always_comb begin
    done = state == DONE;
    busy = state != IDLE;
  end
  // operand capture, magnitude preparation and the shift/subtract iteration
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      xr <= x;
      yr <= y;
      sm <= signed_mode;
    end
    if (state == PREP) begin
      a <= sx ? -xr : xr;
      m <= sy ? -yr : yr;
      p <= '0;
      sq <= sx ^ sy;
      sr <= sx;
      zf <= yr == '0;
      cnt <= CW'(WIDTH - 1);
    end
    if (state == ITER) begin
      p <= diff[WIDTH+1] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      a <= {a[WIDTH-2:0], ~diff[WIDTH+1]};
      cnt <= cnt - CW'(1);
    end
  end
  // result registers: cleared flag on accept, signed fix-up and load in FIX only
  always_ff @(posedge clk)
    if (reset) begin
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      div_by_zero <= 1'b0;
    end else if (state == FIX) begin
      quotient <= zf ? '1 : (sq ? -a : a);
      remainder <= zf ? xr : (sr ? -p : p);
      div_by_zero <= zf;
    end
endmodule
